// File: rtl/alu_issue.sv
// alu_issue: two-stage ALU issue/writeback controller with 32x32 register file; define ALU_ISSUE_FORWARD_EN to bypass alu_out on RAW hazards instead of stalling
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [4:0]  alu_op_code,
  input  logic [31:0] alu_out,
  input  logic        alu_flag_carry,
  input  logic        alu_flag_overflow,
  input  logic        alu_flag_parity,
  input  logic        alu_flag_neg,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [3:0]  flags,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  logic [31:0] rf [32];
  logic        e_valid;
  logic [4:0]  e_op, e_rd;
  logic [31:0] e_a, e_b;
  logic [4:0]  op, rd, ra, rb;
  logic        unused_bits;
  logic        e_wr, e_rsv, e_arith, haz_a, haz_b, accept;
  logic [31:0] src_a, src_b;

  function automatic logic is_wr(input logic [4:0] o);
    return (o >= 5'd1 && o <= 5'd8) || (o >= 5'd16 && o <= 5'd19);
  endfunction

  assign {op, rd, ra, rb} = instr[31:12];
  assign unused_bits = ^instr[11:0];
  assign alu_op_a = e_a;
  assign alu_op_b = e_b;
  assign dbg_data = rf[dbg_addr];

  always_comb begin
    e_wr = e_valid && is_wr(e_op);
    e_rsv = e_valid && e_op != 5'd0 && !is_wr(e_op);
    e_arith = e_op == 5'd16 || e_op == 5'd17;
    haz_a = e_wr && e_rd != 5'd0 && ra == e_rd;
    haz_b = e_wr && e_rd != 5'd0 && rb == e_rd;
`ifdef ALU_ISSUE_FORWARD_EN
    instr_ready = !rst;
    src_a = haz_a ? alu_out : rf[ra];
    src_b = haz_b ? alu_out : rf[rb];
`else
    instr_ready = !rst && !(haz_a || haz_b);
    src_a = rf[ra];
    src_b = rf[rb];
`endif
    accept = instr_valid && instr_ready;
    alu_op_code = e_valid ? e_op : 5'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_op <= '0;
      e_rd <= '0;
      e_a <= '0;
      e_b <= '0;
    end else begin
      e_valid <= accept;
      if (accept) begin
        e_op <= op;
        e_rd <= rd;
        e_a <= src_a;
        e_b <= src_b;
      end
    end
  end

  // R0 is never written, so it reads zero forever after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (e_wr && e_rd != 5'd0) begin
      rf[e_rd] <= alu_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flags <= '0;
      illegal <= 1'b0;
    end else begin
      wb_valid <= e_wr;
      illegal <= e_rsv;
      if (e_wr) begin
        wb_addr <= e_rd;
        wb_data <= alu_out;
        flags <= {e_arith ? alu_flag_carry : flags[3], alu_flag_overflow, alu_flag_parity, alu_flag_neg};
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue with an in-bench ALU and architectural model
module tb_alu_issue;
  logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, instr_ready;
  logic [31:0] instr = '0, alu_op_a, alu_op_b, alu_out, wb_data, dbg_data;
  logic [4:0]  alu_op_code, wb_addr, dbg_addr = '0;
  logic        alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg;
  logic        wb_valid, illegal;
  logic [3:0]  flags;

  typedef struct {
    bit          ill;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  flg;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] m_rf [32];
  logic [3:0]  m_flags;
  int          checks = 0, errors = 0, run = 0, last_run = 0, st;
  logic [4:0]  wr_ops [12] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd16, 5'd17, 5'd18, 5'd19};
`ifdef ALU_ISSUE_FORWARD_EN
  int          raw_stall = 0;
`else
  int          raw_stall = 1;
`endif

  alu_issue dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code), .alu_out(alu_out),
    .alu_flag_carry(alu_flag_carry), .alu_flag_overflow(alu_flag_overflow),
    .alu_flag_parity(alu_flag_parity), .alu_flag_neg(alu_flag_neg),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU behaviour: {carry, overflow, parity, neg, result}
  function automatic logic [35:0] alu_f(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] rot;
    logic c, v, arith;
    r = 32'hDEAD_0000 ^ a;
    c = 1'b0;
    v = 1'b0;
    arith = 1'b1;
    rot = {a, a} >> b[4:0];
    case (o)
      5'd1: begin r = a & b; arith = 1'b0; end
      5'd2: begin r = a | b; arith = 1'b0; end
      5'd3: begin r = a ^ b; arith = 1'b0; end
      5'd4: begin r = ~a; arith = 1'b0; end
      5'd5: begin r = a << b[4:0]; arith = 1'b0; end
      5'd6: begin r = a >> b[4:0]; arith = 1'b0; end
      5'd7: begin r = rot[31:0]; arith = 1'b0; end
      5'd8: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; arith = 1'b0; end
      5'd16: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd17: begin {c, r} = {1'b0, a} - {1'b0, b}; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'd18: begin {c, r} = {1'b0, a} + 33'd1; v = !a[31] && r[31]; end
      5'd19: begin {c, r} = {1'b0, a} - 33'd1; v = a[31] && !r[31]; end
      default: arith = 1'b0;
    endcase
    if (!arith) begin
      c = ~r[0];
      v = r[1];
    end
    return {c, v, ^r, r[31], r};
  endfunction

  always_comb {alu_flag_carry, alu_flag_overflow, alu_flag_parity, alu_flag_neg, alu_out} = alu_f(alu_op_code, alu_op_a, alu_op_b);

  // Architectural model: executes each accepted instruction in program order
  task automatic model(input logic [4:0] o, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    logic [35:0] r;
    exp_t e;
    bit wr;
    wr = (o >= 5'd1 && o <= 5'd8) || (o >= 5'd16 && o <= 5'd19);
    if (o == 5'd0) return;
    e.ill = !wr;
    e.addr = rd;
    e.data = '0;
    if (wr) begin
      r = alu_f(o, m_rf[ra], m_rf[rb]);
      if (rd != 5'd0) m_rf[rd] = r[31:0];
      m_flags = {(o == 5'd16 || o == 5'd17) ? r[35] : m_flags[3], r[34:32]};
      e.data = r[31:0];
    end
    e.flg = m_flags;
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_flags = '0;
    q.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb, output int stalls);
    stalls = 0;
    instr_valid = 1'b1;
    instr = {o, rd, ra, rb, 12'($urandom)};
    #1;
    while (!instr_ready) begin
      stalls++;
      if (stalls > 3) begin
        $display("FAIL issue_stall: instr_ready held 0 for %0d cycles, expected at most 1", stalls);
        $fatal(1);
      end
      @(negedge clk);
      #1;
    end
    model(o, rd, ra, rb);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      instr = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic chk_reg(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), 64'(dbg_data), 64'(exp));
  endtask

  always @(negedge clk) begin
    if (wb_valid || illegal) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=%0b illegal=%0b addr=%0d data=%h, expected no output", wb_valid, illegal, wb_addr, wb_data);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (illegal !== mon_e.ill || wb_valid !== !mon_e.ill || flags !== mon_e.flg ||
            (!mon_e.ill && (wb_addr !== mon_e.addr || wb_data !== mon_e.data))) begin
          errors++;
          $display("FAIL wb_event: got wb_valid=%0b illegal=%0b addr=%0d data=%h flags=%b, expected illegal=%0b addr=%0d data=%h flags=%b",
                   wb_valid, illegal, wb_addr, wb_data, flags, mon_e.ill, mon_e.addr, mon_e.data, mon_e.flg);
        end
      end
    end
    if (wb_valid) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    logic [4:0] o;
    model_reset();
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 64'(instr_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(instr_ready), 64'd1);
    chk("outputs_after_reset", {wb_valid, wb_addr, wb_data, flags, illegal, alu_op_code}, 64'd0);
    @(negedge clk);
    // Reset in the middle of an instruction in flight
    issue(5'd18, 5'd1, 5'd0, 5'd0, st);
    idle(3);
    instr_valid = 1'b1;
    instr = {5'd2, 5'd6, 5'd1, 5'd1, 12'd0};
    @(posedge clk);
    #2;
    rst = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("outputs_async_clear", {wb_valid, wb_addr, wb_data, flags, illegal, alu_op_code}, 64'd0);
    chk("alu_ops_async_clear", {alu_op_a, alu_op_b}, 64'd0);
    chk("ready_in_reset2", 64'(instr_ready), 64'd0);
    @(negedge clk);
    chk("no_wb_after_reset", 64'(wb_valid), 64'd0);
    for (int i = 0; i < 32; i++) chk_reg(5'(i), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("ready_after_release", 64'(instr_ready), 64'd1);
    @(negedge clk);
    // ADD with carry, then carry hold across a logic op
    issue(5'd19, 5'd1, 5'd0, 5'd0, st);
    issue(5'd18, 5'd2, 5'd0, 5'd0, st);
    issue(5'd16, 5'd3, 5'd1, 5'd2, st);
    idle(3);
    chk_reg(5'd3, 32'd0);
    chk_reg(5'd1, 32'hFFFF_FFFF);
    chk("add_carry", 64'(flags[3]), 64'd1);
    @(negedge clk);
    issue(5'd1, 5'd5, 5'd1, 5'd2, st);
    idle(3);
    chk("and_keeps_carry", 64'(flags), 64'b1010);
    // Back-to-back RAW on r4
    issue(5'd18, 5'd4, 5'd0, 5'd0, st);
    issue(5'd18, 5'd4, 5'd4, 5'd4, st);
    chk("raw_stall_cycles", 64'(st), 64'(raw_stall));
    idle(3);
    chk_reg(5'd4, 32'd2);
    @(negedge clk);
    // Write to r0 and a NOP
    issue(5'd16, 5'd0, 5'd1, 5'd2, st);
    issue(5'd0, 5'd9, 5'd1, 5'd2, st);
    idle(3);
    chk_reg(5'd0, 32'd0);
    chk_reg(5'd9, 32'd0);
    chk("r0_write_flags", 64'(flags), 64'b1000);
    @(negedge clk);
    // Reserved opcode
    issue(5'd9, 5'd7, 5'd1, 5'd2, st);
    idle(3);
    chk("reserved_flags", 64'(flags), 64'b1000);
    chk_reg(5'd7, 32'd0);
    @(negedge clk);
    // Throughput: 8 independent XORs
    last_run = 0;
    for (int i = 0; i < 8; i++) issue(5'd3, 5'(8 + i), 5'(1 + i % 4), 5'(2 + i % 3), st);
    idle(3);
    chk("xor_run_length", 64'(last_run), 64'd8);
    for (int i = 8; i < 16; i++) chk_reg(5'(i), m_rf[i]);
    @(negedge clk);
    // Randomized traffic with frequent hazards
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        k = $urandom_range(0, 9);
        if (k == 0) o = $urandom_range(0, 1) ? 5'($urandom_range(9, 15)) : 5'($urandom_range(20, 31));
        else if (k == 1) o = 5'd0;
        else o = wr_ops[$urandom_range(0, 11)];
        issue(o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), st);
      end
    end
    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("final_flags", 64'(flags), 64'(m_flags));
    for (int i = 0; i < 32; i++) chk_reg(5'(i), m_rf[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
